// File: rtl/byte_xform_arbiter.sv
// Round-robin arbiter sharing one combinational byte-transform unit between two requesters.
// Optional grant counters are enabled with the XFA_STATS_EN macro.
module byte_xform_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  input  logic              rsp_ready,
  output logic              cct_clear,
  output logic [DATA_W-1:0] cct_input,
  input  logic [DATA_W-1:0] cct_output,
  output logic              busy
`ifdef XFA_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   cct_input_q, cct_input_d;
  logic                cct_clear_q, cct_clear_d;

  logic grant_valid;
  logic grant_id;
  logic rsp_fire;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds valid/data stable until that edge, and ready never depends on anything
  // but the current state and the presented valids.
  always_comb begin
    grant_valid = (state_q == S_IDLE) && clear_n && (req0_valid || req1_valid);
    grant_id    = req0_valid ? (req1_valid ? ~rr_last_q : 1'b0) : 1'b1;
    rsp_fire    = (state_q == S_RESP) && rsp_valid_q && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      cct_input_q <= '0;
      cct_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      cct_input_q <= cct_input_d;
      cct_clear_q <= cct_clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_last_d   = rr_last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    cct_input_d = cct_input_q;
    cct_clear_d = cct_clear_q;
    req0_ready  = grant_valid && !grant_id;
    req1_ready  = grant_valid && grant_id;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          cct_input_d = grant_id ? req1_data : req0_data;
          rsp_id_d    = grant_id;
          cct_clear_d = 1'b0;
        end
      end
      S_EXEC: begin
        rsp_data_d  = cct_output;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        // Returning to IDLE puts the unit back into its cleared, zero-operand condition.
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          rr_last_d   = rsp_id_q;
          cct_clear_d = 1'b1;
          cct_input_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign cct_clear = cct_clear_q;
  assign cct_input = cct_input_q;
  assign busy      = (state_q != S_IDLE);

`ifdef XFA_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

  // Counters saturate at all-ones; a clear pulse beats a grant in the same cycle.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (stats_clr) begin
      grant_cnt0_d = '0;
      grant_cnt1_d = '0;
    end else if (grant_valid) begin
      if (!grant_id && (grant_cnt0_q != {CNT_W{1'b1}})) grant_cnt0_d = grant_cnt0_q + 1'b1;
      if (grant_id && (grant_cnt1_q != {CNT_W{1'b1}}))  grant_cnt1_d = grant_cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
